// File: rtl/uart_rx_frontend_if.sv
// Serial-line and decoded-byte signals of the UART receive front end.
// The master side drives the line and bit period; the slave side is the receiver.
interface uart_rx_frontend_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 10
);
  logic                 rx;
  logic [DIV_W-1:0]     clk_per_bit;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx, clk_per_bit,
    input  rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    input  rx, clk_per_bit,
    output rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 LSB-first UART receiver with a runtime-programmable bit period.
// Emits each good byte with a one-cycle rx_valid, or a one-cycle frame_err on a low stop bit.
module uart_rx_frontend #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_frontend_if.slave    bus
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 busy_q;

  logic [DIV_W-1:0]     half_m1;
  logic [DIV_W-1:0]     div_m1;
  logic                 last_bit;

  assign half_m1  = (div >> 1) - DIV_W'(1);
  assign div_m1   = div - DIV_W'(1);
  assign last_bit = (bit_idx == IDX_W'(DATA_BITS - 1));

  // Presetting to 1 keeps reset release from looking like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s && (bus.clk_per_bit != '0)) begin
            state  <= START;
            cnt    <= '0;
            div    <= bus.clk_per_bit;
            busy_q <= 1'b1;
          end
        end
        // Half a bit in, confirm the start bit so short glitches are dropped.
        START: begin
          if (cnt == half_m1) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (cnt == div_m1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (last_bit) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (cnt == div_m1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data_q  <= shift;
              rx_valid_q <= 1'b1;
              state      <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        // A line stuck low after a framing error must go high before we rearm.
        BREAK: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: good frames, back-to-back, framing error,
// glitch rejection, mid-frame reset and the disabled receiver.
module tb_uart_rx_frontend;

  localparam int DATA_BITS = 8;
  localparam int DIV_W     = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_frontend_if #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) bus ();

  uart_rx_frontend #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int checks = 0;
  int errors = 0;

  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cycle = 0;
  int prev_valid_cycle = 0;
  int last_err_cycle = 0;
  bit both_seen = 1'b0;
  bit busy_seen = 1'b0;
  int start_cycle = 0;

  // Strobes are sampled on the falling edge, away from the DUT's update edge.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_cnt        = valid_cnt + 1;
      prev_valid_cycle = last_valid_cycle;
      last_valid_cycle = cycle_cnt;
    end
    if (bus.frame_err) begin
      err_cnt        = err_cnt + 1;
      last_err_cycle = cycle_cnt;
    end
    if (bus.rx_valid && bus.frame_err) both_seen = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one full frame; must be called at a falling edge and returns at one.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int div);
    bus.rx      = 1'b0;
    start_cycle = cycle_cnt;
    repeat (div) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      bus.rx = data[i];
      repeat (div) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (div) @(negedge clk);
  endtask

  function automatic int expLatency(input int div);
    return 3 + (DATA_BITS + 1) * div + div / 2;
  endfunction

  int v0;
  int e0;
  logic [15:0] pat;

  initial begin
    bus.rx          = 1'b1;
    bus.clk_per_bit = {8'd4, 2'b00};
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h0);
    checkOutput("reset_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single good byte
    applyStimulus(8'hA5, 1'b1, 16);
    repeat (4) @(negedge clk);
    checkOutput("t1_valid_cnt", 32'(valid_cnt), 32'd1);
    checkOutput("t1_rx_data", 32'(bus.rx_data), 32'hA5);
    checkOutput("t1_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("t1_latency", 32'(last_valid_cycle - start_cycle), 32'(expLatency(16)));
    checkOutput("t1_busy_idle", 32'(bus.busy), 32'h0);

    // 2: back-to-back frames
    applyStimulus(8'h00, 1'b1, 16);
    applyStimulus(8'hFF, 1'b1, 16);
    repeat (4) @(negedge clk);
    checkOutput("t2_valid_cnt", 32'(valid_cnt), 32'd3);
    checkOutput("t2_spacing", 32'(last_valid_cycle - prev_valid_cycle), 32'd160);
    checkOutput("t2_rx_data", 32'(bus.rx_data), 32'hFF);
    checkOutput("t2_err_cnt", 32'(err_cnt), 32'd0);

    // 3: stop bit low, line held low
    applyStimulus(8'h3C, 1'b0, 16);
    repeat (100) @(negedge clk);
    checkOutput("t3_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("t3_err_latency", 32'(last_err_cycle - start_cycle), 32'(expLatency(16)));
    checkOutput("t3_valid_cnt", 32'(valid_cnt), 32'd3);
    checkOutput("t3_rx_data", 32'(bus.rx_data), 32'hFF);
    checkOutput("t3_busy_held", 32'(bus.busy), 32'h1);
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t3_busy_release", 32'(bus.busy), 32'h0);
    checkOutput("t3_err_single", 32'(err_cnt), 32'd1);

    // 4: short glitch on an idle line
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t4_busy_during", 32'(bus.busy), 32'h1);
    repeat (30) @(negedge clk);
    checkOutput("t4_busy_after", 32'(bus.busy), 32'h0);
    checkOutput("t4_valid_cnt", 32'(valid_cnt), 32'd3);
    checkOutput("t4_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("t4_rx_data", 32'(bus.rx_data), 32'hFF);

    // 5: reset during data bit 4, then a clean frame
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = i[0];
      repeat (16) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t5_rst_rx_data", 32'(bus.rx_data), 32'h0);
    checkOutput("t5_rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("t5_rst_valid", 32'(bus.rx_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("t5_no_stale_valid", 32'(valid_cnt), 32'd3);
    checkOutput("t5_no_stale_err", 32'(err_cnt), 32'd1);
    applyStimulus(8'h81, 1'b1, 16);
    repeat (4) @(negedge clk);
    checkOutput("t5_valid_cnt", 32'(valid_cnt), 32'd4);
    checkOutput("t5_rx_data", 32'(bus.rx_data), 32'h81);

    // 6: disabled receiver ignores the line, then div=8
    bus.clk_per_bit = '0;
    busy_seen       = 1'b0;
    v0              = valid_cnt;
    e0              = err_cnt;
    pat             = 16'b1011_0011_1000_1010;
    for (int i = 0; i < 48; i++) begin
      bus.rx = pat[i % 16];
      repeat (1 + (i % 5)) @(negedge clk);
    end
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("t6_busy_seen", 32'(busy_seen), 32'h0);
    checkOutput("t6_valid_cnt", 32'(valid_cnt), 32'(v0));
    checkOutput("t6_err_cnt", 32'(err_cnt), 32'(e0));
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    bus.clk_per_bit = 10'd8;
    applyStimulus(8'h5A, 1'b1, 8);
    repeat (4) @(negedge clk);
    checkOutput("t6_valid_cnt_div8", 32'(valid_cnt), 32'(v0 + 1));
    checkOutput("t6_rx_data", 32'(bus.rx_data), 32'h5A);
    checkOutput("t6_latency", 32'(last_valid_cycle - start_cycle), 32'(expLatency(8)));

    checkOutput("never_both_strobes", 32'(both_seen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
